// File: rtl/seq_alu_if.sv
// Request/response bundle between the ALU and its caller: operands and opcode in,
// result, persistent flags and the busy/done handshake out.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       mode;
    logic             in_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             flag_zero;
    logic             flag_carry;

    modport master (
        output in1, in2, mode, in_valid,
        input  busy, done, out, flag_zero, flag_carry
    );

    modport slave (
        input  in1, in2, mode, in_valid,
        output busy, done, out, flag_zero, flag_carry
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with persistent zero/carry flags and an iterative shift-add multiplier.
// state | meaning
// IDLE  | accepting requests; single-cycle ops complete at the accepting edge
// MUL   | shift-add iterations running, requests ignored, out/flags held
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    seq_alu_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     part;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     res;

    // Upper half accumulates the multiplicand; lower half starts as the multiplier
    // and shifts out one bit per iteration, ending as the low product bits.
    always_comb begin
        part     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {part, acc[WIDTH-1:1]};
    end

    always_comb begin
        res = '0;
        case (bus.mode)
            3'b000:  res = {1'b0, bus.in1} + {1'b0, bus.in2};
            3'b001:  res = {1'b0, bus.in1} - {1'b0, bus.in2};
            3'b011:  res = {1'b0, bus.in1 & bus.in2};
            3'b100:  res = {1'b0, bus.in1 | bus.in2};
            3'b101:  res = {1'b0, bus.in1 ^ bus.in2};
            3'b110:  res = {1'b0, bus.in1} + {1'b0, bus.in2} + {{WIDTH{1'b0}}, bus.flag_carry};
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            mcand          <= '0;
            acc            <= '0;
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.out        <= '0;
            bus.flag_zero  <= 1'b0;
            bus.flag_carry <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.mode == 3'b111) begin
                            mcand    <= bus.in1;
                            acc      <= {{WIDTH{1'b0}}, bus.in2};
                            cnt      <= CNT_W'(WIDTH);
                            bus.busy <= 1'b1;
                            state    <= MUL;
                        end else if (bus.mode == 3'b010) begin
                            bus.flag_zero  <= (bus.in1 == bus.in2);
                            bus.flag_carry <= (bus.in1 < bus.in2);
                            bus.done       <= 1'b1;
                        end else begin
                            bus.out       <= res[WIDTH-1:0];
                            bus.flag_zero <= (res[WIDTH-1:0] == '0);
                            // logic ops leave carry untouched
                            if (bus.mode == 3'b000 || bus.mode == 3'b001 || bus.mode == 3'b110)
                                bus.flag_carry <= res[WIDTH];
                            bus.done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bus.out        <= acc_next[WIDTH-1:0];
                        bus.flag_carry <= |acc_next[2*WIDTH-1:WIDTH];
                        bus.flag_zero  <= (acc_next[WIDTH-1:0] == '0);
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
